// File: rtl/reg_cmd_pkg.sv
// Shared opcodes, FSM state encoding and read timeout for the register command controller.
package reg_cmd_pkg;

   localparam logic [7:0] CMD_WR     = 8'hAA;
   localparam logic [7:0] CMD_RD     = 8'hBB;
   localparam int         RD_TIMEOUT = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5
   } state_t;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Decodes serial byte frames (AA addr data / BB addr) into register-file writes and reads,
// returning read data to the transmitter and flagging malformed or unexpected bytes.
module reg_cmd_ctrl
   import reg_cmd_pkg::*;
#(
   parameter int dataWidth = 8,
   parameter int addrWidth = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [dataWidth-1:0] rx_data,
   input  logic                 rx_valid,
   input  logic [dataWidth-1:0] rf_rdData,
   input  logic                 rf_rdData_valid,
   input  logic                 tx_busy,
   output logic [dataWidth-1:0] rf_wrData,
   output logic [addrWidth-1:0] rf_addr,
   output logic                 rf_wrEn,
   output logic                 rf_rdEn,
   output logic [dataWidth-1:0] tx_data,
   output logic                 tx_valid,
   output logic                 cmd_err,
   output logic                 busy
);

   localparam logic [dataWidth-1:0] ADDR_MASK    = {dataWidth{1'b1}} << addrWidth;
   localparam logic [2:0]           TIMEOUT_LAST = 3'(RD_TIMEOUT - 1);

   state_t     state;
   logic [2:0] wait_cnt;
   logic       addr_legal;

   // An address byte is only usable if nothing is set above the register address range.
   assign addr_legal = (rx_data & ADDR_MASK) == '0;
   assign busy       = (state != IDLE);

   // Strobes default low every cycle so each one is a single-cycle pulse; data outputs
   // only change when a frame loads them, so they hold between commands.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         rf_addr   <= '0;
         rf_wrData <= '0;
         tx_data   <= '0;
         rf_wrEn   <= 1'b0;
         rf_rdEn   <= 1'b0;
         tx_valid  <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         rf_wrEn  <= 1'b0;
         rf_rdEn  <= 1'b0;
         tx_valid <= 1'b0;
         cmd_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (rx_data == dataWidth'(CMD_WR)) begin
                     state <= WR_ADDR;
                  end else if (rx_data == dataWidth'(CMD_RD)) begin
                     state <= RD_ADDR;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            WR_ADDR: begin
               if (rx_valid) begin
                  if (addr_legal) begin
                     rf_addr <= rx_data[addrWidth-1:0];
                     state   <= WR_DATA;
                  end else begin
                     cmd_err <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            WR_DATA: begin
               if (rx_valid) begin
                  rf_wrData <= rx_data;
                  rf_wrEn   <= 1'b1;
                  state     <= IDLE;
               end
            end
            RD_ADDR: begin
               if (rx_valid) begin
                  if (addr_legal) begin
                     rf_addr  <= rx_data[addrWidth-1:0];
                     rf_rdEn  <= 1'b1;
                     wait_cnt <= '0;
                     state    <= RD_WAIT;
                  end else begin
                     cmd_err <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            RD_WAIT: begin
               if (rx_valid) begin
                  cmd_err <= 1'b1;
               end
               // Read data wins over the timeout if both land on the final wait cycle.
               if (rf_rdData_valid) begin
                  tx_data <= rf_rdData;
                  state   <= TX_SEND;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  cmd_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            TX_SEND: begin
               if (rx_valid) begin
                  cmd_err <= 1'b1;
               end
               if (!tx_busy) begin
                  tx_valid <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl: frame-level stimulus pushes expected strobes with their
// cycle numbers, and a negedge monitor pops and compares every strobe the DUT produces.
module tb_reg_cmd_ctrl;
   import reg_cmd_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] rf_rdData;
   logic       rf_rdData_valid;
   logic       tx_busy;
   logic [7:0] rf_wrData;
   logic [3:0] rf_addr;
   logic       rf_wrEn;
   logic       rf_rdEn;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       cmd_err;
   logic       busy;

   reg_cmd_ctrl #(.dataWidth(8), .addrWidth(4)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rf_rdData(rf_rdData), .rf_rdData_valid(rf_rdData_valid), .tx_busy(tx_busy),
      .rf_wrData(rf_wrData), .rf_addr(rf_addr), .rf_wrEn(rf_wrEn), .rf_rdEn(rf_rdEn),
      .tx_data(tx_data), .tx_valid(tx_valid), .cmd_err(cmd_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [3:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t        wr_q[$];
   ev_t        rd_q[$];
   ev_t        tx_q[$];
   int         err_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   int         rf_delay = 0;
   logic [7:0] ref_mem[16];
   logic [7:0] rf_mem[16];
   logic [3:0] rf_a;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation, including its cycle.
   always @(negedge clk) begin
      ev_t e;
      int  ec;
      if (rst === 1'b0) begin
         checkOutput("wr_rd_overlap", 32'(rf_wrEn & rf_rdEn), 32'd0);
         if (rf_wrEn === 1'b1) begin
            if (wr_q.size() == 0) checkOutput("wr_unexpected", 32'd1, 32'd0);
            else begin
               e = wr_q.pop_front();
               checkOutput("wr_cycle", cyc, e.cyc);
               checkOutput("wr_addr", 32'(rf_addr), 32'(e.addr));
               checkOutput("wr_data", 32'(rf_wrData), 32'(e.data));
            end
         end
         if (rf_rdEn === 1'b1) begin
            if (rd_q.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
            else begin
               e = rd_q.pop_front();
               checkOutput("rd_cycle", cyc, e.cyc);
               checkOutput("rd_addr", 32'(rf_addr), 32'(e.addr));
            end
         end
         if (tx_valid === 1'b1) begin
            if (tx_q.size() == 0) checkOutput("tx_unexpected", 32'd1, 32'd0);
            else begin
               e = tx_q.pop_front();
               checkOutput("tx_cycle", cyc, e.cyc);
               checkOutput("tx_data", 32'(tx_data), 32'(e.data));
            end
         end
         if (cmd_err === 1'b1) begin
            if (err_q.size() == 0) checkOutput("err_unexpected", 32'd1, 32'd0);
            else begin
               ec = err_q.pop_front();
               checkOutput("err_cycle", cyc, ec);
            end
         end
      end
   end

   // Register-file model: stores writes, answers a read rf_delay cycles late (never if >= 4).
   initial begin
      rf_rdData_valid = 1'b0;
      rf_rdData       = 8'h00;
      forever begin
         @(negedge clk);
         rf_rdData_valid = 1'b0;
         rf_rdData       = 8'($urandom);
         if (rst === 1'b0 && rf_wrEn === 1'b1) rf_mem[rf_addr] = rf_wrData;
         if (rst === 1'b0 && rf_rdEn === 1'b1) begin
            rf_a = rf_addr;
            if (rf_delay < RD_TIMEOUT) begin
               for (int i = 0; i < rf_delay; i++) begin
                  @(negedge clk);
                  rf_rdData = 8'($urandom);
               end
               rf_rdData       = rf_mem[rf_a];
               rf_rdData_valid = 1'b1;
            end
         end
      end
   end

   task automatic start_byte(input logic [7:0] b, input int gap, output int edge_n);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      edge_n   = cyc + 1;
   endtask

   task automatic end_byte();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [7:0] data, input int gap);
      int e;
      start_byte(CMD_WR, gap, e);
      end_byte();
      start_byte({4'h0, addr}, gap, e);
      end_byte();
      start_byte(data, gap, e);
      wr_q.push_back('{e, addr, data});
      ref_mem[addr] = data;
      end_byte();
      checkOutput("busy_after_write", 32'(busy), 32'd0);
   endtask

   task automatic do_read(input logic [3:0] addr, input int d, input int b, input bit stray, input int gap);
      int         e, k, cap, txe;
      logic [7:0] exp;
      rf_delay = d;
      tx_busy  = (b > 0);
      exp      = ref_mem[addr];
      start_byte(CMD_RD, gap, e);
      end_byte();
      start_byte({4'h0, addr}, gap, k);
      rd_q.push_back('{k, addr, 8'h00});
      cap = k + 1 + d;
      txe = cap + 1 + b;
      if (d >= RD_TIMEOUT) err_q.push_back(k + RD_TIMEOUT);
      else tx_q.push_back('{txe, 4'h0, exp});
      end_byte();
      if (d >= RD_TIMEOUT) begin
         while (cyc <= k + RD_TIMEOUT) @(negedge clk);
      end else begin
         while (cyc <= txe) begin
            if (stray && d >= 1 && cyc == k) begin
               err_q.push_back(k + 1);
               rx_data  = 8'($urandom);
               rx_valid = 1'b1;
            end else begin
               rx_valid = 1'b0;
            end
            if (b > 0 && cyc == cap + b) tx_busy = 1'b0;
            if (cyc >= cap) checkOutput("tx_data_hold", 32'(tx_data), 32'(exp));
            @(negedge clk);
         end
      end
      rx_valid = 1'b0;
      tx_busy  = 1'b0;
      checkOutput("busy_after_read", 32'(busy), 32'd0);
   endtask

   task automatic do_bad_opcode(input logic [7:0] b, input int gap);
      int e;
      start_byte(b, gap, e);
      err_q.push_back(e);
      end_byte();
      checkOutput("busy_after_bad_op", 32'(busy), 32'd0);
   endtask

   task automatic do_bad_addr(input logic [7:0] op, input logic [7:0] addr, input int gap);
      int e;
      start_byte(op, gap, e);
      end_byte();
      start_byte(addr, gap, e);
      err_q.push_back(e);
      end_byte();
      checkOutput("busy_after_bad_addr", 32'(busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
      checkOutput({tag, "_rf_wrData"}, 32'(rf_wrData), 32'd0);
      checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      checkOutput({tag, "_strobes"}, 32'({rf_wrEn, rf_rdEn, tx_valid, cmd_err}), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Write frame cut short by reset after the address, then a junk opcode from IDLE.
   task automatic do_reset_frame(input logic [3:0] addr);
      int e;
      start_byte(CMD_WR, 0, e);
      end_byte();
      start_byte({4'h0, addr}, 0, e);
      end_byte();
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("reset_mid_frame");
      rst = 1'b0;
      do_bad_opcode(8'h55, 1);
   endtask

   task automatic applyStimulus(input int kind);
      logic [7:0] b;
      int         gap;
      gap = int'($urandom_range(0, 2));
      case (kind)
         0, 1: do_write(4'($urandom), 8'($urandom), gap);
         2: do_read(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), gap);
         3: do_read(4'($urandom), 9, 0, 1'b0, gap);
         4: begin
            do b = 8'($urandom); while (b == CMD_WR || b == CMD_RD);
            do_bad_opcode(b, gap);
         end
         5: do_bad_addr(($urandom_range(0, 1) == 1) ? CMD_WR : CMD_RD,
                        {4'($urandom_range(1, 15)), 4'($urandom)}, gap);
         default: do_reset_frame(4'($urandom));
      endcase
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 8'($urandom);
         rf_mem[i]  = ref_mem[i];
      end
      ref_mem[3] = 8'h0F;
      rf_mem[3]  = 8'h0F;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_busy  = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      do_write(4'h5, 8'h0A, 0);
      do_read(4'h5, 0, 0, 1'b0, 0);
      do_read(4'h3, 0, 0, 1'b0, 0);
      do_read(4'h3, 0, 5, 1'b0, 1);
      do_bad_opcode(8'h33, 0);
      do_bad_addr(CMD_WR, 8'h12, 0);
      do_read(4'h2, 9, 0, 1'b0, 0);
      do_reset_frame(4'h7);
      do_read(4'h9, 2, 1, 1'b1, 0);

      for (int n = 0; n < 60; n++) begin
         applyStimulus(int'($urandom_range(0, 6)));
      end

      repeat (10) @(negedge clk);
      checkOutput("wr_q_left", wr_q.size(), 32'd0);
      checkOutput("rd_q_left", rd_q.size(), 32'd0);
      checkOutput("tx_q_left", tx_q.size(), 32'd0);
      checkOutput("err_q_left", err_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 Parameters SHALL be: dataWidth, default 8, byte/register width; addrWidth, default 4, register address width (depth 16).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  dataWidth  received byte from the serial receiver.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- rf_rdData  in  dataWidth  read data from the register file.
- rf_rdData_valid  in  1  rf_rdData valid.
- tx_busy  in  1  transmitter cannot accept a byte.
- rf_wrData  out  dataWidth  register file write data.
- rf_addr  out  addrWidth  register file address.
- rf_wrEn  out  1  one-cycle write strobe.
- rf_rdEn  out  1  one-cycle read strobe.
- tx_data  out  dataWidth  byte to transmitter.
- tx_valid  out  1  one-cycle transmit strobe.
- cmd_err  out  1  one-cycle error pulse.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The block SHALL decode byte frames: write = 0xAA, addr, data; read = 0xBB, addr.
REQ-004 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT and TX_SEND; bytes are consumed only on cycles with rx_valid=1.
REQ-005 In IDLE: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> stay IDLE and pulse cmd_err next cycle.
REQ-006 In WR_ADDR/RD_ADDR, an addr byte with any bit above addrWidth-1 set SHALL abort the frame: -> IDLE, cmd_err pulse, no register access.
REQ-007 In WR_ADDR, a legal addr byte SHALL be latched into rf_addr -> WR_DATA.
REQ-008 In WR_DATA, the data byte SHALL drive rf_wrData, with rf_wrEn=1 for exactly the next cycle -> IDLE.
REQ-009 In RD_ADDR, a legal addr byte SHALL be latched into rf_addr, with rf_rdEn=1 for exactly the next cycle -> RD_WAIT.
REQ-010 In RD_WAIT, the first cycle with rf_rdData_valid=1 SHALL capture rf_rdData into tx_data -> TX_SEND.
REQ-011 RD_WAIT SHALL time out 4 cycles after entry without rf_rdData_valid: -> IDLE with a cmd_err pulse.
REQ-012 In TX_SEND, tx_valid SHALL pulse for one cycle on the first cycle tx_busy=0 -> IDLE; while tx_busy=1, hold with tx_data stable.
REQ-013 A byte arriving in RD_WAIT or TX_SEND SHALL be dropped with a cmd_err pulse, without changing state.
REQ-014 rf_wrEn and rf_rdEn SHALL never be high in the same cycle.
REQ-015 rf_addr, rf_wrData and tx_data SHALL hold their last values between commands.

Reset
REQ-016 With rst=1 at a clock edge, state SHALL go to IDLE and all outputs SHALL be 0, regardless of the frame in progress.
REQ-017 A frame interrupted by reset SHALL produce no rf_wrEn, rf_rdEn or tx_valid after reset is released.

Structure
REQ-018 Package reg_cmd_pkg SHALL hold the opcodes (CMD_WR=8'hAA, CMD_RD=8'hBB), the state encoding and RD_TIMEOUT=4.
REQ-019 The block SHALL be a single FSM with a 3-bit timeout counter; no sub-module is required.

Verification
REQ-020 AA,05,0A -> rf_addr=5, rf_wrData=0x0A and rf_wrEn pulse one cycle after the data byte; regFile[5] reads back 10.
REQ-021 BB,03 with a register-file model returning 0x0F after 1 cycle -> rf_rdEn pulse, then tx_valid pulse with tx_data=0x0F.
REQ-022 Same read with tx_busy=1 held for 5 cycles -> tx_valid delayed until tx_busy=0, with tx_data stable at 0x0F throughout.
REQ-023 Bytes 0x33, then AA,12 -> two cmd_err pulses; no rf_wrEn at any point.
REQ-024 BB,02 with rf_rdData_valid never asserted -> cmd_err 4 cycles after RD_WAIT entry; no tx_valid.
REQ-025 AA,07 then rst=1 for one cycle, then 0x55 -> no rf_wrEn; 0x55 yields a cmd_err pulse from IDLE.
